// File: rtl/opb_master_pkg.sv
// Shared definitions for the OPB master bridge.
//   - default bus widths
//   - controller state encoding (legacy-compatible localparam constants)
//   - response code values reported on rsp_code
//   - counter width helper used by opb_master_tout_cnt
package opb_master_pkg;

    localparam int unsigned OPB_AWIDTH = 32;
    localparam int unsigned OPB_DWIDTH = 32;

    // Controller states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_XFER    = 3'd2;
    localparam logic [2:0] ST_BACKOFF = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Response codes
    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_ERRACK  = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;
    localparam logic [1:0] RSP_RETRY   = 2'b11;

    // Bits needed to count 0 .. limit-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/opb_master_tout_cnt.sv
// Load/enable/hold cycle counter with a terminal flag.
// Used by the bridge both for the bus timeout and for the retry back-off gap.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   load  in   restart the count at zero (wins over en)
//   en    in   count this cycle; count holds while low
//   last  out  count has reached LIMIT-1, i.e. this is the LIMIT-th counted cycle
module opb_master_tout_cnt
    import opb_master_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam int unsigned CW = cnt_width(LIMIT);
    localparam logic [CW-1:0] LAST_VAL = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;

    // Saturates at LAST_VAL so a stalled owner never sees the flag wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (en && !last) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/opb_master_bridge.sv
// OPB bus initiator: turns one user command into one OPB master transfer and
// reports the outcome. One transfer outstanding; handles arbitration grant,
// slave retry with back-off, and bus timeout.
// Ports:
//   OPB_Clk, OPB_Rst                 bus clock / async active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only when idle)
//   cmd_rnw, cmd_addr, cmd_be, cmd_wdata   command fields, captured on accept
//   rsp_valid                        one-cycle completion pulse
//   rsp_rdata, rsp_code              read data / status, held until next completion
//   M_request, M_select, M_RNW       master control to arbiter and bus
//   M_ABus, M_BE, M_DBus             master buses, zero while not selected (OR-bus)
//   M_seqAddr, M_busLock             tied low
//   OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup, OPB_DBus   bus inputs
module opb_master_bridge
    import opb_master_pkg::*;
#(
    parameter int unsigned C_OPB_AWIDTH     = OPB_AWIDTH,
    parameter int unsigned C_OPB_DWIDTH     = OPB_DWIDTH,
    parameter int unsigned C_TIMEOUT_CYCLES = 16,
    parameter int unsigned C_MAX_RETRY      = 7,
    parameter int unsigned C_RETRY_GAP      = 2
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    // user command side
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [0:C_OPB_AWIDTH-1]   cmd_addr,
    input  logic [0:C_OPB_DWIDTH/8-1] cmd_be,
    input  logic [0:C_OPB_DWIDTH-1]   cmd_wdata,
    // user response side
    output logic                      rsp_valid,
    output logic [0:C_OPB_DWIDTH-1]   rsp_rdata,
    output logic [1:0]                rsp_code,
    // OPB master outputs
    output logic                      M_request,
    output logic                      M_select,
    output logic                      M_RNW,
    output logic [0:C_OPB_AWIDTH-1]   M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1] M_BE,
    output logic [0:C_OPB_DWIDTH-1]   M_DBus,
    output logic                      M_seqAddr,
    output logic                      M_busLock,
    // OPB inputs
    input  logic                      OPB_MGrant,
    input  logic                      OPB_xferAck,
    input  logic                      OPB_errAck,
    input  logic                      OPB_retry,
    input  logic                      OPB_toutSup,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus
);

    logic [2:0]                state_q, state_d;
    logic                      rnw_q;
    logic [0:C_OPB_AWIDTH-1]   addr_q;
    logic [0:C_OPB_DWIDTH/8-1] be_q;
    logic [0:C_OPB_DWIDTH-1]   wdata_q;
    logic [7:0]                retry_cnt_q;
    logic [0:C_OPB_DWIDTH-1]   rdata_q;
    logic [1:0]                code_q;

    logic accept;
    logic in_xfer;
    logic ack_hit;
    logic retry_hit;
    logic retry_limit;
    logic tout_hit;
    logic tout_last;
    logic gap_last;

    assign in_xfer     = (state_q == ST_XFER);
    assign accept      = (state_q == ST_IDLE) && cmd_valid;
    // Priority within a transfer cycle: xferAck, then retry, then timeout.
    assign ack_hit     = in_xfer && OPB_xferAck;
    assign retry_hit   = in_xfer && !OPB_xferAck && OPB_retry;
    assign retry_limit = (retry_cnt_q == 8'(C_MAX_RETRY));
    assign tout_hit    = in_xfer && !OPB_xferAck && !OPB_retry && !OPB_toutSup && tout_last;

    // Timeout: restarted on every entry to XFER, frozen while the slave suppresses.
    opb_master_tout_cnt #(
        .LIMIT (C_TIMEOUT_CYCLES)
    ) u_tout_cnt (
        .clk  (OPB_Clk),
        .rst  (OPB_Rst),
        .load ((state_q == ST_REQ) && OPB_MGrant),
        .en   (in_xfer && !OPB_toutSup),
        .last (tout_last)
    );

    // Back-off gap: restarted on the retry, runs through BACKOFF.
    opb_master_tout_cnt #(
        .LIMIT (C_RETRY_GAP)
    ) u_gap_cnt (
        .clk  (OPB_Clk),
        .rst  (OPB_Rst),
        .load (retry_hit),
        .en   (state_q == ST_BACKOFF),
        .last (gap_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (OPB_MGrant) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (ack_hit) begin
                    state_d = ST_DONE;
                end else if (retry_hit) begin
                    state_d = retry_limit ? ST_DONE : ST_BACKOFF;
                end else if (tout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_BACKOFF: begin
                if (gap_last) state_d = ST_REQ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command capture; the command inputs are not looked at again until idle.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            rnw_q   <= cmd_rnw;
            addr_q  <= cmd_addr;
            be_q    <= cmd_be;
            wdata_q <= cmd_wdata;
        end
    end

    // Retry count is per command, not per attempt.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            retry_cnt_q <= '0;
        end else if (accept) begin
            retry_cnt_q <= '0;
        end else if (retry_hit) begin
            retry_cnt_q <= retry_cnt_q + 8'd1;
        end
    end

    // Response registers hold their value between completions; read data is
    // only replaced by an acknowledged read.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            rdata_q <= '0;
            code_q  <= RSP_OK;
        end else begin
            if (ack_hit) begin
                code_q <= OPB_errAck ? RSP_ERRACK : RSP_OK;
                if (rnw_q) rdata_q <= OPB_DBus;
            end else if (retry_hit && retry_limit) begin
                code_q <= RSP_RETRY;
            end else if (tout_hit) begin
                code_q <= RSP_TIMEOUT;
            end
        end
    end

    // All bus outputs decode straight from state so the async reset clears
    // them in the same cycle it is asserted.
    assign cmd_ready = (state_q == ST_IDLE) && !OPB_Rst;
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_code  = code_q;

    assign M_request = (state_q == ST_REQ);
    assign M_select  = in_xfer;
    assign M_RNW     = in_xfer && rnw_q;
    assign M_ABus    = in_xfer ? addr_q : '0;
    assign M_BE      = in_xfer ? be_q : '0;
    // Write data only on writes, so reads leave the OR-ed data bus to the slave.
    assign M_DBus    = (in_xfer && !rnw_q) ? wdata_q : '0;
    assign M_seqAddr = 1'b0;
    assign M_busLock = 1'b0;

endmodule
